// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI display bus arbiter.
package spi_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

  // Pin levels while nobody owns the bus.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;
  localparam logic DC_IDLE   = 1'b0;

  // Counter width able to hold max_val; a zero max still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Round-robin picker: first set pending bit searching upward from ptr+1,
// wrapping at N. Purely combinational.
module rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk offsets 1..N from ptr so ptr itself is considered last.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!found && pending[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI display bus between N drawing engines. Requests are
// latched into a pending vector, granted round-robin, the winner gets a
// one-cycle start pulse and owns the pins until its done pulse (or the
// watchdog), after which the bus is held idle for GAP cycles.
//
// Handshake: i_req[k] is a level/pulse, any high cycle queues engine k.
// o_start[k] is a single-cycle pulse issued once per grant. The engine
// drives i_mosi/i_dc/i_cs[k] from the next cycle and ends ownership with a
// single-cycle i_done[k]; done from an engine that is not the owner is
// ignored. There is no back-pressure on any of these signals.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_start,
  input  logic [N-1:0] i_done,
  input  logic [N-1:0] i_mosi,
  input  logic [N-1:0] i_dc,
  input  logic [N-1:0] i_cs,
  output logic         o_mosi,
  output logic         o_dc,
  output logic         o_cs,
  output logic [N-1:0] o_grant,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout,
  output arb_state_e   o_state
);

  localparam int IW    = $clog2(N);
  localparam int GAP_W = cnt_width(GAP);
  localparam int RUN_W = cnt_width(TIMEOUT);

  arb_state_e       state, state_next;
  logic [N-1:0]     pending;
  logic [N-1:0]     clr_mask;
  logic [N-1:0]     grant_q;
  logic [IW-1:0]    ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_next;
  logic [N-1:0]     pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             done_g;
  logic             wd_hit;
  logic             done_pulse;
  logic             timeout_pulse;

  rr_picker #(.N(N)) u_picker (
    .pending (pending),
    .ptr     (ptr),
    .grant   (pick_grant),
    .index   (pick_idx)
  );

  // Owner's done only; anything else on i_done is noise.
  assign done_g = |(i_done & grant_q);

  // Saturating RUN-cycle count including the current cycle.
  assign run_cnt_next = (run_cnt == RUN_W'(TIMEOUT)) ? run_cnt : run_cnt + RUN_W'(1);
  assign wd_hit       = (TIMEOUT != 0) && (run_cnt_next == RUN_W'(TIMEOUT));

  // Pending bits of the owner are only retired in START.
  assign clr_mask = (state == START) ? grant_q : '0;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Request latch: a new request on the clearing edge wins and stays queued.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) pending <= '0;
    else        pending <= (pending & ~clr_mask) | i_req;
  end

  // Grant and round-robin pointer, captured when leaving IDLE. ptr doubles
  // as the owner index for the bus mux.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant_q <= '0;
      ptr     <= IW'(N - 1);
    end else if (state == IDLE && pending != '0) begin
      grant_q <= pick_grant;
      ptr     <= pick_idx;
    end
  end

  // Guard-gap counter: cleared on entry to GUARD, saturates at GAP.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      gap_cnt <= '0;
    end else if (state != GUARD && state_next == GUARD) begin
      gap_cnt <= '0;
    end else if (state == GUARD && gap_cnt != GAP_W'(GAP)) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Watchdog counter: cleared on entry to RUN, saturates at TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)              run_cnt <= '0;
    else if (state == START) run_cnt <= '0;
    else if (state == RUN)   run_cnt <= run_cnt_next;
  end

  // Next-state logic with the two single-cycle status pulses.
  always_comb begin
    state_next    = state;
    done_pulse    = 1'b0;
    timeout_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != '0) state_next = START;
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        if (done_g) begin
          state_next = GUARD;
        end else if (wd_hit) begin
          state_next    = GUARD;
          timeout_pulse = 1'b1;
        end
      end
      GUARD: begin
        if (gap_cnt == GAP_W'(GAP - 1)) begin
          state_next = IDLE;
          done_pulse = (pending == '0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin mux: owner's lines straight through in RUN, idle levels otherwise.
  always_comb begin
    o_mosi = MOSI_IDLE;
    o_dc   = DC_IDLE;
    o_cs   = CS_IDLE;
    if (state == RUN) begin
      o_mosi = i_mosi[ptr];
      o_dc   = i_dc[ptr];
      o_cs   = i_cs[ptr];
    end
  end

  assign o_start   = (state == START) ? grant_q : '0;
  assign o_grant   = (state != IDLE) ? grant_q : '0;
  assign o_busy    = (state != IDLE);
  assign o_done    = done_pulse;
  assign o_timeout = timeout_pulse;
  assign o_state   = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (N=4, GAP=4, TIMEOUT=100).
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int N       = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 100;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [N-1:0] i_req  = '0;
  logic [N-1:0] i_done = '0;
  logic [N-1:0] i_mosi = '0;
  logic [N-1:0] i_dc   = '0;
  logic [N-1:0] i_cs   = '1;
  logic [N-1:0] o_start;
  logic [N-1:0] o_grant;
  logic         o_mosi, o_dc, o_cs, o_busy, o_done, o_timeout;
  arb_state_e   o_state;

  int n_cmp = 0;
  int n_bad = 0;

  spi_bus_arbiter #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .o_start   (o_start),
    .i_done    (i_done),
    .i_mosi    (i_mosi),
    .i_dc      (i_dc),
    .i_cs      (i_cs),
    .o_mosi    (o_mosi),
    .o_dc      (o_dc),
    .o_cs      (o_cs),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout),
    .o_state   (o_state)
  );

  // Clock.
  always #5 i_clk = ~i_clk;

  // Monitor: wait (bounded) for a start pulse from an IDLE/GUARD point,
  // counting elapsed cycles, o_done pulses and any CS-low while waiting.
  task automatic wait_start(input int budget, output int idx, output int cycles,
                            output int dones, output bit cs_ok);
    idx = -1; cycles = 0; dones = 0; cs_ok = 1'b1;
    while (o_start == '0 && cycles < budget) begin
      if (o_done) dones++;
      if (o_cs !== 1'b1) cs_ok = 1'b0;
      @(negedge i_clk);
      cycles++;
    end
    for (int k = 0; k < N; k++) if (o_start[k]) idx = k;
  endtask

  // Driver: engine k owns the bus for len RUN cycles then pulses done.
  // Called at the negedge inside the START cycle; returns in GUARD cycle 1.
  task automatic run_engine(input int k, input int len);
    for (int c = 1; c <= len; c++) begin
      @(negedge i_clk);
      i_req     = '0;
      i_cs      = '1;
      i_cs[k]   = 1'b0;
      i_mosi    = '0;
      i_mosi[k] = (c % 2) == 1;
      i_done    = (c == len) ? (N'(1) << k) : '0;
    end
    @(negedge i_clk);
    i_done = '0; i_cs = '1; i_mosi = '0; i_dc = '0;
  endtask

  // Monitor: step GAP+2 cycles from GUARD cycle 1 counting o_done.
  task automatic drain(output int dones);
    dones = 0;
    for (int c = 0; c < GAP + 2; c++) begin
      if (o_done) dones++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (o_cs !== 1'b1) begin n_bad++; $display("FAIL rst_cs: got %b expected 1", o_cs); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_grant !== '0) begin n_bad++; $display("FAIL rst_grant: got %b expected 0000", o_grant); end
    n_cmp++; if (o_start !== '0) begin n_bad++; $display("FAIL rst_start: got %b expected 0000", o_start); end
    n_cmp++; if ({o_mosi, o_dc, o_done, o_timeout} !== 4'b0000)
      begin n_bad++; $display("FAIL rst_misc: got %b expected 0000", {o_mosi, o_dc, o_done, o_timeout}); end
    @(negedge i_clk); i_rst = 1'b1;
    begin
      int bad = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge i_clk);
        if (o_cs !== 1'b1 || o_busy !== 1'b0 || o_grant !== '0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rst_idle_hold: got %0d bad cycles expected 0", bad); end
    end
  endtask

  task automatic test_all_four();
    int idx, cyc, dn, total;
    bit cs_ok;
    total = 0;
    @(negedge i_clk); i_req = 4'b1111;
    @(negedge i_clk); i_req = '0;
    for (int k = 0; k < N; k++) begin
      wait_start(30, idx, cyc, dn, cs_ok);
      total += dn;
      n_cmp++; if (idx != k) begin n_bad++; $display("FAIL all4_order[%0d]: got %0d expected %0d", k, idx, k); end
      if (k > 0) begin
        n_cmp++; if (cyc != GAP + 1 || !cs_ok)
          begin n_bad++; $display("FAIL all4_gap[%0d]: got %0d cs_ok=%0b expected %0d cs_ok=1", k, cyc, cs_ok, GAP + 1); end
      end
      run_engine(k, 3);
    end
    drain(dn);
    total += dn;
    n_cmp++; if (total != 1) begin n_bad++; $display("FAIL all4_done_count: got %0d expected 1", total); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL all4_idle: got %b expected 0", o_busy); end
  endtask

  task automatic test_single();
    int bad;
    logic em, ed;
    @(negedge i_clk); i_req = 4'b0100;
    @(negedge i_clk); i_req = '0;
    n_cmp++; if (o_start !== '0 || o_busy !== 1'b0)
      begin n_bad++; $display("FAIL single_latency: got start=%b busy=%b expected 0000/0", o_start, o_busy); end
    @(negedge i_clk);
    n_cmp++; if (o_start !== 4'b0100 || o_grant !== 4'b0100 || o_cs !== 1'b1)
      begin n_bad++; $display("FAIL single_start: got start=%b grant=%b cs=%b expected 0100/0100/1", o_start, o_grant, o_cs); end
    bad = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge i_clk);
      em = (c % 2) == 1;
      ed = ((c / 2) % 2) == 1;
      i_mosi = em ? 4'b0100 : 4'b1011;
      i_dc   = ed ? 4'b0100 : 4'b1011;
      i_cs   = 4'b1011;
      i_done = (c == 10) ? 4'b1011 : (c == 50) ? 4'b0100 : 4'b0000;
      #1;
      if (o_mosi !== em || o_dc !== ed || o_cs !== 1'b0 || o_start !== '0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_mux: got %0d bad RUN cycles expected 0", bad); end
    @(negedge i_clk);
    i_done = '0; i_cs = '1; i_mosi = '0; i_dc = '0;
    for (int g = 1; g <= GAP; g++) begin
      if (g > 1) @(negedge i_clk);
      n_cmp++; if (o_cs !== 1'b1 || o_mosi !== 1'b0 || o_grant !== 4'b0100 || o_done !== (g == GAP))
        begin n_bad++; $display("FAIL single_guard[%0d]: got cs=%b mosi=%b grant=%b done=%b expected 1/0/0100/%0b",
                                g, o_cs, o_mosi, o_grant, o_done, g == GAP); end
    end
    @(negedge i_clk);
    n_cmp++; if (o_busy !== 1'b0 || o_grant !== '0 || o_done !== 1'b0)
      begin n_bad++; $display("FAIL single_back_idle: got busy=%b grant=%b done=%b expected 0/0000/0", o_busy, o_grant, o_done); end
  endtask

  task automatic test_rerequest();
    int idx, cyc, dn, total;
    int exp_order[4];
    bit cs_ok;
    exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 1;
    // Move the pointer to engine 0 first.
    @(negedge i_clk); i_req = 4'b0001;
    @(negedge i_clk); i_req = '0;
    wait_start(10, idx, cyc, dn, cs_ok);
    n_cmp++; if (idx != 0) begin n_bad++; $display("FAIL rereq_prelude: got %0d expected 0", idx); end
    run_engine(0, 2);
    drain(dn);
    total = 0;
    @(negedge i_clk); i_req = 4'b1110;
    @(negedge i_clk); i_req = '0;
    for (int t = 0; t < 4; t++) begin
      wait_start(30, idx, cyc, dn, cs_ok);
      total += dn;
      n_cmp++; if (idx != exp_order[t])
        begin n_bad++; $display("FAIL rereq_order[%0d]: got %0d expected %0d", t, idx, exp_order[t]); end
      if (t == 0) i_req = 4'b0010;
      run_engine(exp_order[t], 2);
    end
    drain(dn);
    total += dn;
    n_cmp++; if (total != 1) begin n_bad++; $display("FAIL rereq_done_count: got %0d expected 1", total); end
  endtask

  task automatic test_timeout();
    int idx, cyc, dn, bad;
    bit cs_ok;
    @(negedge i_clk); i_req = 4'b0001;
    @(negedge i_clk); i_req = '0;
    wait_start(10, idx, cyc, dn, cs_ok);
    n_cmp++; if (idx != 0) begin n_bad++; $display("FAIL tmo_first: got %0d expected 0", idx); end
    bad = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge i_clk);
      i_cs  = 4'b1110;
      i_req = (c == 50) ? 4'b0100 : 4'b0000;
      #1;
      if (c < TIMEOUT && (o_timeout !== 1'b0 || o_cs !== 1'b0)) bad++;
      if (c == TIMEOUT) begin
        n_cmp++; if (o_timeout !== 1'b1 || o_grant !== 4'b0001)
          begin n_bad++; $display("FAIL tmo_pulse: got tmo=%b grant=%b expected 1/0001", o_timeout, o_grant); end
      end
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tmo_early: got %0d bad cycles expected 0", bad); end
    @(negedge i_clk); i_cs = '1;
    n_cmp++; if (o_timeout !== 1'b0 || o_cs !== 1'b1 || o_busy !== 1'b1 || o_grant !== 4'b0001)
      begin n_bad++; $display("FAIL tmo_guard: got tmo=%b cs=%b busy=%b grant=%b expected 0/1/1/0001",
                              o_timeout, o_cs, o_busy, o_grant); end
    wait_start(20, idx, cyc, dn, cs_ok);
    n_cmp++; if (idx != 2 || cyc != GAP + 1 || dn != 0)
      begin n_bad++; $display("FAIL tmo_next: got idx=%0d cyc=%0d done=%0d expected 2/%0d/0", idx, cyc, dn, GAP + 1); end
    run_engine(2, 4);
    drain(dn);
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL tmo_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_reset_mid_run();
    int idx, cyc, dn, bad;
    bit cs_ok;
    @(negedge i_clk); i_req = 4'b1000;
    @(negedge i_clk); i_req = '0;
    wait_start(10, idx, cyc, dn, cs_ok);
    n_cmp++; if (idx != 3) begin n_bad++; $display("FAIL mid_first: got %0d expected 3", idx); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge i_clk);
      i_cs = 4'b0111; i_mosi = 4'b1000; i_dc = 4'b1000;
      i_req = (c == 3) ? 4'b0010 : 4'b0000;
    end
    #1;
    n_cmp++; if (o_cs !== 1'b0 || o_mosi !== 1'b1 || o_dc !== 1'b1)
      begin n_bad++; $display("FAIL mid_run_bus: got cs=%b mosi=%b dc=%b expected 0/1/1", o_cs, o_mosi, o_dc); end
    #2 i_rst = 1'b0;
    #1;
    n_cmp++; if (o_cs !== 1'b1 || o_mosi !== 1'b0 || o_dc !== 1'b0 || o_busy !== 1'b0 ||
                 o_grant !== '0 || o_start !== '0 || o_done !== 1'b0 || o_timeout !== 1'b0)
      begin n_bad++; $display("FAIL mid_async: got cs=%b mosi=%b dc=%b busy=%b grant=%b expected 1/0/0/0/0000",
                              o_cs, o_mosi, o_dc, o_busy, o_grant); end
    i_cs = '1; i_mosi = '0; i_dc = '0;
    @(negedge i_clk); @(negedge i_clk); i_rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_cs !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid_pending_cleared: got %0d busy cycles expected 0", bad); end
    i_req = 4'b1000;
    @(negedge i_clk); i_req = '0;
    wait_start(10, idx, cyc, dn, cs_ok);
    n_cmp++; if (idx != 3 || cyc != 1)
      begin n_bad++; $display("FAIL mid_after_reset: got idx=%0d cyc=%0d expected 3/1", idx, cyc); end
    run_engine(3, 2);
    drain(dn);
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL mid_done_count: got %0d expected 1", dn); end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_rerequest();
    test_timeout();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: got no completion expected finish before 200000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
